// File: rtl/mem_lsu.sv
// mem_lsu -- MEM pipeline stage with a load/store unit.
//
// Sits between ex_mem and mem_wb. Non-memory ops pass wd/wreg/wdata straight
// through combinationally. Loads and stores run one req/ack transaction on the
// data bus and hold stallreq_o until it completes. Loads get byte/half lane
// extraction with sign or zero extension. Misaligned half/word accesses are
// refused without touching the bus, and a bus that never acks is abandoned
// after TIMEOUT busy cycles (TIMEOUT = 0 waits forever).
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   wd_i/wreg_i     destination register and write enable from ex_mem
//   wdata_i         ALU result from ex_mem
//   memop_i         0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW, other NONE
//   addr_i          effective byte address
//   sdata_i         store data
//   wd_o/wreg_o     destination register and write enable to mem_wb
//   wdata_o         write-back data to mem_wb
//   stallreq_o      hold the pipeline; ex_mem inputs stay stable while set
//   mem_req_o       bus request (registered)
//   mem_we_o        1 = store (registered)
//   mem_addr_o      word-aligned bus address (registered)
//   mem_sel_o       byte-lane enables (registered)
//   mem_data_o      store data replicated onto the lanes (registered)
//   mem_data_i      read data, valid with mem_ack_i
//   mem_ack_i       one-cycle bus completion pulse
//   excp_o          one-cycle code in DONE: 0 none, 1 misaligned, 2 timeout
module mem_lsu #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REGADDR_W  = 5,
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           memop_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [31:0]          sdata_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 stallreq_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [3:0]           mem_sel_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i,
  output logic [1:0]           excp_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic [1:0]       err_q;
  logic             load_q;
  logic             signed_q;
  size_t            size_q;
  logic [1:0]       off_q;

  logic  op_load;
  logic  op_store;
  logic  op_signed;
  logic  op_mem;
  size_t op_size;
  logic  misaligned;

  // Opcode decode; unknown codes fall through as NONE.
  always_comb begin
    op_load   = 1'b0;
    op_store  = 1'b0;
    op_signed = 1'b0;
    op_size   = SZ_BYTE;
    case (memop_i)
      4'd1: begin op_load = 1'b1; op_signed = 1'b1; end
      4'd2: begin op_load = 1'b1; end
      4'd3: begin op_load = 1'b1; op_signed = 1'b1; op_size = SZ_HALF; end
      4'd4: begin op_load = 1'b1; op_size = SZ_HALF; end
      4'd5: begin op_load = 1'b1; op_size = SZ_WORD; end
      4'd6: begin op_store = 1'b1; end
      4'd7: begin op_store = 1'b1; op_size = SZ_HALF; end
      4'd8: begin op_store = 1'b1; op_size = SZ_WORD; end
      default: ;
    endcase
    op_mem     = op_load | op_store;
    misaligned = ((op_size == SZ_HALF) && addr_i[0]) ||
                 ((op_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
  end

  // Lane enables for an access of size sz at byte offset off.
  function automatic logic [3:0] lane_sel(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_sel = BIG_ENDIAN ? (4'b1000 >> off) : (4'b0001 << off);
      // Upper half is addressed by offset 0 in big-endian, offset 2 in little.
      SZ_HALF: lane_sel = (off[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: store_lanes = {4{d[7:0]}};
      SZ_HALF: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= EXC_NONE;
      load_q     <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= '0;
      mem_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_mem) begin
            load_q   <= op_load;
            signed_q <= op_signed;
            size_q   <= op_size;
            off_q    <= addr_i[1:0];
            cnt_q    <= '0;
            if (misaligned) begin
              err_q   <= EXC_MISALIGN;
              state_q <= DONE;
            end else begin
              err_q      <= EXC_NONE;
              mem_req_o  <= 1'b1;
              mem_we_o   <= op_store;
              mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_sel_o  <= lane_sel(op_size, addr_i[1:0]);
              mem_data_o <= op_store ? store_lanes(op_size, sdata_i) : '0;
              state_q    <= BUSY;
            end
          end
        end
        BUSY: begin
          // Ack is checked first so a coincident ack beats the timeout.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            rdata_q   <= mem_data_i;
            state_q   <= DONE;
          end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            mem_req_o <= 1'b0;
            err_q     <= EXC_TIMEOUT;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          err_q   <= EXC_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load data extraction from the word captured at ack.
  logic [1:0]  byte_lane;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    byte_lane = BIG_ENDIAN ? ~off_q : off_q;
    rd_shift  = rdata_q >> {byte_lane, 3'b000};
    rd_byte   = rd_shift[7:0];
    rd_half   = (off_q[1] ^ BIG_ENDIAN) ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_data = rdata_q;
    endcase
  end

  // Stage outputs; held at zero throughout reset.
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    excp_o     = EXC_NONE;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (op_mem) stallreq_o = 1'b1;
          else        wreg_o     = wreg_i;
        end
        BUSY: begin
          wd_o       = wd_i;
          wdata_o    = wdata_i;
          stallreq_o = 1'b1;
        end
        DONE: begin
          wd_o    = wd_i;
          wreg_o  = wreg_i & load_q & (err_q == EXC_NONE);
          wdata_o = load_q ? load_data : wdata_i;
          excp_o  = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model builds the expected
// outputs for each cycle and one compare process checks them at the falling
// edge; literal checks after key transactions pin the model itself.
module tb_mem_lsu;

  localparam int TO = 16;
  localparam bit BE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  memop_i;
  logic [31:0] addr_i;
  logic [31:0] sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic [1:0]  excp_o;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .REGADDR_W(5), .TIMEOUT(TO), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .memop_i(memop_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .excp_o(excp_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected values for the current cycle, plus which fields are meaningful.
  logic        ck_en = 1'b0, ck_req = 1'b1, ck_bus = 1'b0, ck_sdata = 1'b0, ck_wdata = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0;
  logic        e_stall, e_req, e_we, e_wreg;
  logic [4:0]  e_wd;
  logic [31:0] e_wdata, e_addr, e_data;
  logic [3:0]  e_sel;
  logic [1:0]  e_excp;

  int          stall_run = 0, last_stall = 0, req_run = 0, last_req = 0;
  logic [31:0] last_wdata = '0, last_data = '0;
  logic [3:0]  last_sel = '0;

  always @(negedge clk) begin
    if (ck_en) begin
      chk("stallreq", 32'(stallreq_o), 32'(e_stall));
      chk("wreg", 32'(wreg_o), 32'(e_wreg));
      chk("wd", 32'(wd_o), 32'(e_wd));
      chk("excp", 32'(excp_o), 32'(e_excp));
      if (ck_req)   chk("mem_req", 32'(mem_req_o), 32'(e_req));
      if (ck_wdata) chk("wdata", wdata_o, e_wdata);
      if (ck_bus) begin
        chk("mem_we", 32'(mem_we_o), 32'(e_we));
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_sel", 32'(mem_sel_o), 32'(e_sel));
      end
      if (ck_sdata) chk("mem_data", mem_data_o, e_data);
      if (stallreq_o === 1'b1) stall_run <= stall_run + 1;
      else begin
        if (stall_run != 0) last_stall <= stall_run;
        stall_run <= 0;
      end
      if (mem_req_o === 1'b1) req_run <= req_run + 1;
      else begin
        if (req_run != 0) last_req <= req_run;
        req_run <= 0;
      end
      if (e_done) last_wdata <= wdata_o;
      if (e_busy) begin
        last_sel  <= mem_sel_o;
        last_data <= mem_data_o;
      end
    end
  end

  // ---- model ----
  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_sel(input int n, input int off);
    logic [3:0] s = '0;
    for (int p = off; p < off + n; p++) s[BE ? 3 - p : p] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_sdata(input int n, input logic [31:0] d);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input int off, input logic [31:0] d);
    int n = nbytes(op);
    bit sgn = (op == 4'd1) || (op == 4'd3);
    longint v = 0;
    longint b;
    for (int p = off; p < off + n; p++) begin
      b = BE ? longint'(d[8*(3-p) +: 8]) : longint'(d[8*p +: 8]);
      if (BE) v = v * 256 + b;
      else    v = v + (b << (8 * (p - off)));
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---- driver ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic none_cycle(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, input logic ack);
    memop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; mem_ack_i = ack;
    mem_data_i = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_wreg = wreg; e_wd = wd; e_wdata = wdata; e_excp = 2'd0;
    ck_wdata = 1'b1; ck_bus = 1'b0; ck_sdata = 1'b0;
    cyc();
    mem_ack_i = 1'b0;
  endtask

  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int waits, input bit never,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    int  n   = nbytes(op);
    bit  ld  = (op <= 4'd5);
    int  off = int'(addr[1:0]);
    bit  mis = (off % n) != 0;
    int  nb;
    memop_i = op; addr_i = addr; sdata_i = sdata; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_ack_i = 1'b0; mem_data_i = $urandom;
    e_stall = 1'b1; e_req = 1'b0; e_wreg = 1'b0; e_wd = wd; e_excp = 2'd0;
    ck_wdata = 1'b0; ck_bus = 1'b0; ck_sdata = 1'b0;
    cyc();
    if (!mis) begin
      nb = never ? TO : waits + 1;
      e_req = 1'b1; e_we = !ld; e_addr = addr & ~32'd3; e_sel = m_sel(n, off);
      e_data = m_sdata(n, sdata); ck_bus = 1'b1; ck_sdata = !ld; e_busy = 1'b1;
      for (int i = 0; i < nb; i++) begin
        mem_ack_i  = (!never && i == waits);
        mem_data_i = mem_ack_i ? rdata : $urandom;
        cyc();
      end
      e_busy = 1'b0; ck_bus = 1'b0; ck_sdata = 1'b0; mem_ack_i = 1'b0;
    end
    e_done = 1'b1; e_stall = 1'b0; e_req = 1'b0;
    e_excp = mis ? 2'd1 : (never ? 2'd2 : 2'd0);
    e_wreg = wreg && ld && (e_excp == 2'd0);
    e_wdata = m_load(op, off, rdata);
    ck_wdata = e_wreg;
    cyc();
    e_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234; memop_i = 4'd0;
    addr_i = '0; sdata_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    cyc();
    // Reset: every output zero even with live-looking inputs.
    e_stall = 0; e_req = 0; e_wreg = 0; e_wd = 0; e_wdata = 0; e_excp = 0;
    e_we = 0; e_addr = 0; e_sel = 0; e_data = 0;
    ck_wdata = 1; ck_bus = 1; ck_sdata = 1; ck_en = 1;
    cyc();
    rst = 1'b0;

    // Pass-through.
    none_cycle(4'd0, 5'd3, 1'b1, 32'h1234, 1'b0);
    none_cycle(4'd0, 5'd31, 1'b0, 32'hFFFF_0000, 1'b0);
    none_cycle(4'd12, 5'd17, 1'b1, 32'hA5A5_5A5A, 1'b1);

    // LB / LBU back to back, zero-wait ack.
    do_mem(4'd1, 32'h101, 32'h0, 32'h1182_3344, 0, 0, 5'd7, 1'b1, 32'h0);
    chk("lb_wdata", last_wdata, 32'hFFFF_FF82);
    chk("lb_sel", 32'(last_sel), 32'h4);
    chk("lb_stall_len", 32'(last_stall), 32'd2);
    chk("lb_req_len", 32'(last_req), 32'd1);
    do_mem(4'd2, 32'h101, 32'h0, 32'h1182_3344, 0, 0, 5'd8, 1'b1, 32'h0);
    chk("lbu_wdata", last_wdata, 32'h0000_0082);

    // SH with three wait states.
    do_mem(4'd7, 32'h102, 32'hAAAA_BEEF, 32'h0, 3, 0, 5'd9, 1'b1, 32'h0);
    chk("sh_sel", 32'(last_sel), 32'h3);
    chk("sh_data", last_data, 32'hBEEF_BEEF);
    chk("sh_stall_len", 32'(last_stall), 32'd5);

    // Misaligned word and half.
    do_mem(4'd5, 32'h102, 32'h0, 32'h0, 0, 0, 5'd10, 1'b1, 32'h0);
    chk("lw_mis_stall_len", 32'(last_stall), 32'd1);
    do_mem(4'd3, 32'h101, 32'h0, 32'h0, 0, 0, 5'd11, 1'b1, 32'h0);

    // Remaining lane/extension patterns.
    do_mem(4'd3, 32'h102, 32'h0, 32'h1234_8001, 1, 0, 5'd12, 1'b1, 32'h0);
    chk("lh_wdata", last_wdata, 32'hFFFF_8001);
    do_mem(4'd4, 32'h100, 32'h0, 32'h8001_7FFF, 0, 0, 5'd13, 1'b1, 32'h0);
    chk("lhu_wdata", last_wdata, 32'h0000_8001);
    do_mem(4'd6, 32'h103, 32'h1234_565A, 32'h0, 0, 0, 5'd14, 1'b1, 32'h0);
    chk("sb_data", last_data, 32'h5A5A_5A5A);
    chk("sb_sel", 32'(last_sel), 32'h1);
    do_mem(4'd8, 32'h10C, 32'hDEAD_BEEF, 32'h0, 1, 0, 5'd15, 1'b1, 32'h0);
    do_mem(4'd5, 32'h200, 32'h0, 32'h0BAD_F00D, 2, 0, 5'd16, 1'b1, 32'h0);
    do_mem(4'd1, 32'h200, 32'h0, 32'h7F00_0000, 0, 0, 5'd18, 1'b1, 32'h0);
    none_cycle(4'd0, 5'd1, 1'b1, 32'h0000_0001, 1'b0);

    // Timeout, then a late ack that must be ignored.
    do_mem(4'd5, 32'h300, 32'h0, 32'h0, 0, 1, 5'd19, 1'b1, 32'h0);
    chk("to_req_len", 32'(last_req), 32'd16);
    chk("to_stall_len", 32'(last_stall), 32'd17);
    none_cycle(4'd0, 5'd20, 1'b1, 32'h2222_2222, 1'b1);
    none_cycle(4'd0, 5'd21, 1'b0, 32'h3333_3333, 1'b0);

    // Reset while BUSY.
    memop_i = 4'd5; addr_i = 32'h400; wd_i = 5'd22; wreg_i = 1'b1;
    e_stall = 1; e_req = 0; e_wreg = 0; e_wd = 5'd22; e_excp = 0; ck_wdata = 0;
    cyc();
    e_req = 1;
    cyc();
    cyc();
    rst = 1'b1; memop_i = 4'd0;
    e_stall = 0; e_wreg = 0; e_wd = 0; e_wdata = 0; e_excp = 0; ck_wdata = 1; ck_req = 0;
    cyc();
    rst = 1'b0; ck_req = 1;
    none_cycle(4'd0, 5'd9, 1'b1, 32'h55, 1'b1);
    do_mem(4'd5, 32'h204, 32'h0, 32'hCAFE_BABE, 0, 0, 5'd23, 1'b1, 32'h0);
    chk("lw_after_rst", last_wdata, 32'hCAFE_BABE);
    none_cycle(4'd0, 5'd0, 1'b0, 32'h0, 1'b0);

    ck_en = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
